id_ex_stage: RTL and testbench

ID/EX pipeline boundary, sitting between the decoder (producer of control_signals_t) and the execute stage. Registers the decoded control bundle, PC, register-file operands and immediate each cycle. Detects load-use hazards and inserts a bubble while stalling ID/IF. Honours EX backpressure and branch/jump flushes, and keeps a saturating load-use stall counter for performance debug.

---
 rtl/id_ex_stage_pkg.sv | 74 +++++++
 rtl/id_ex_stage_load_use_detect.sv | 38 +++
 rtl/id_ex_stage.sv | 95 +++++++++
 tb/tb_id_ex_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared control-bundle types for the ID/EX boundary: decoded control fields,
// the bubble constant, and the datapath payload carried alongside the control.
package id_ex_stage_pkg;

    localparam int unsigned PKG_XLEN  = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_sel_t;

    typedef enum logic [1:0] {
        SRC_A_RS1, SRC_A_PC, SRC_A_ZERO, SRC_A_MEMWB
    } src_a_sel_t;

    typedef enum logic [1:0] {
        SRC_B_RS2, SRC_B_IMM, SRC_B_FOUR, SRC_B_MEMWB
    } src_b_sel_t;

    typedef enum logic [1:0] {
        WB_FROM_ALU, WB_FROM_MEM, WB_FROM_PC4
    } wb_sel_t;

    typedef enum logic [3:0] {
        BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JAL, BR_JALR
    } branch_type_t;

    typedef enum logic [3:0] {
        OP_NOP, OP_R_TYPE, OP_I_TYPE, OP_LOAD, OP_STORE,
        OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
    } instr_type_t;

    typedef struct packed {
        alu_op_t                alu_op;
        logic                   regwen;
        imm_sel_t               imm_sel;
        src_a_sel_t             A_sel;
        src_b_sel_t             B_sel;
        wb_sel_t                wb_sel;
        branch_type_t           branch_type;
        instr_type_t            instruction_type;
        logic [REG_IDX_W-1:0]   rs1;
        logic [REG_IDX_W-1:0]   rs2;
        logic [REG_IDX_W-1:0]   rd;
    } control_signals_t;

    // Harmless no-op: never writes a register and never redirects.
    localparam control_signals_t CTRL_BUBBLE = '{
        alu_op:           ALU_ADD,
        regwen:           1'b0,
        imm_sel:          IMM_NONE,
        A_sel:            SRC_A_ZERO,
        B_sel:            SRC_B_RS2,
        wb_sel:           WB_FROM_ALU,
        branch_type:      BR_NONE,
        instruction_type: OP_NOP,
        rs1:              '0,
        rs2:              '0,
        rd:               '0
    };

    typedef struct packed {
        logic [PKG_XLEN-1:0] pc;
        logic [PKG_XLEN-1:0] rs1_data;
        logic [PKG_XLEN-1:0] rs2_data;
        logic [PKG_XLEN-1:0] imm;
    } id_ex_payload_t;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detection between the ID instruction and a
// load currently sitting in EX.
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic             id_valid,
    input  control_signals_t id_ctrl,
    input  logic             ex_valid,
    input  control_signals_t ex_ctrl,
    output logic             load_use_c
);

    logic rs1_used;
    logic rs2_used;
    logic ex_is_load_wr;

    always_comb begin
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        case (id_ctrl.instruction_type)
            OP_LUI, OP_AUIPC, OP_JAL, OP_NOP: rs1_used = 1'b0;
            default:                          rs1_used = 1'b1;
        endcase
        case (id_ctrl.instruction_type)
            OP_R_TYPE, OP_STORE, OP_BRANCH: rs2_used = 1'b1;
            default:                        rs2_used = 1'b0;
        endcase
    end

    // x0 is never a real destination, so a load to x0 cannot create a hazard.
    assign ex_is_load_wr = ex_valid && (ex_ctrl.instruction_type == OP_LOAD)
                           && ex_ctrl.regwen && (ex_ctrl.rd != '0);

    assign load_use_c = id_valid && ex_is_load_wr
                        && ((rs1_used && (id_ctrl.rs1 == ex_ctrl.rd))
                         || (rs2_used && (id_ctrl.rs2 == ex_ctrl.rd)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX backpressure,
// flush handling and a saturating load-use stall counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN        = PKG_XLEN,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  control_signals_t       id_ctrl,
    input  logic [XLEN-1:0]        id_pc,
    input  logic [XLEN-1:0]        id_rs1_data,
    input  logic [XLEN-1:0]        id_rs2_data,
    input  logic [XLEN-1:0]        id_imm,
    input  logic                   flush,
    input  logic                   ex_ready,
    output logic                   id_stall,
    output logic                   ex_valid,
    output control_signals_t       ex_ctrl,
    output logic [XLEN-1:0]        ex_pc,
    output logic [XLEN-1:0]        ex_rs1_data,
    output logic [XLEN-1:0]        ex_rs2_data,
    output logic [XLEN-1:0]        ex_imm,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic                   valid_q, valid_d;
    control_signals_t       ctrl_q, ctrl_d;
    id_ex_payload_t         payload_q, payload_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   load_use;

    load_use_detect u_load_use_detect (
        .id_valid   (id_valid),
        .id_ctrl    (id_ctrl),
        .ex_valid   (valid_q),
        .ex_ctrl    (ctrl_q),
        .load_use_c (load_use)
    );

    // A flush kills the ID instruction anyway, so there is nothing to freeze.
    assign id_stall = !flush && (load_use || !ex_ready);

    // Priority: flush, then backpressure hold, then load-use bubble, then capture.
    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        payload_d = payload_q;
        cnt_d     = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_BUBBLE;
        end else if (!ex_ready) begin
            valid_d = valid_q;
        end else if (load_use) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_BUBBLE;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + STALL_CNT_W'(1);
            end
        end else begin
            valid_d            = id_valid;
            ctrl_d             = id_valid ? id_ctrl : CTRL_BUBBLE;
            payload_d.pc       = PKG_XLEN'(id_pc);
            payload_d.rs1_data = PKG_XLEN'(id_rs1_data);
            payload_d.rs2_data = PKG_XLEN'(id_rs2_data);
            payload_d.imm      = PKG_XLEN'(id_imm);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_BUBBLE;
            payload_q <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            payload_q <= payload_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_ctrl     = ctrl_q;
    assign ex_pc       = XLEN'(payload_q.pc);
    assign ex_rs1_data = XLEN'(payload_q.rs1_data);
    assign ex_rs2_data = XLEN'(payload_q.rs2_data);
    assign ex_imm      = XLEN'(payload_q.imm);
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage; a second instance with a 2-bit
// counter shares the stimulus to exercise saturation.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    control_signals_t id_ctrl;
    logic [31:0]      id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic             flush, ex_ready;

    logic             id_stall, ex_valid;
    control_signals_t ex_ctrl;
    logic [31:0]      ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [15:0]      stall_count;

    logic             s_id_stall, s_ex_valid;
    control_signals_t s_ex_ctrl;
    logic [31:0]      s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
    logic [1:0]       s_stall_count;

    int n_cmp = 0;
    int n_err = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .flush(flush), .ex_ready(ex_ready),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .stall_count(stall_count)
    );

    id_ex_stage #(.STALL_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .flush(flush), .ex_ready(ex_ready),
        .id_stall(s_id_stall), .ex_valid(s_ex_valid), .ex_ctrl(s_ex_ctrl),
        .ex_pc(s_ex_pc), .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data),
        .ex_imm(s_ex_imm), .stall_count(s_stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic             valid;
        control_signals_t ctrl;
        logic [31:0]      pc;
        logic             flush;
        logic             ready;
        logic             exp_stall;
        logic             exp_valid;
        control_signals_t exp_ctrl;
        logic [31:0]      exp_pc;
        int               exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic control_signals_t mk(instr_type_t t, logic we,
                                            logic [4:0] r1, logic [4:0] r2, logic [4:0] rd);
        control_signals_t c;
        c.alu_op           = ALU_XOR;
        c.regwen           = we;
        c.imm_sel          = IMM_I;
        c.A_sel            = SRC_A_RS1;
        c.B_sel            = SRC_B_IMM;
        c.wb_sel           = WB_FROM_MEM;
        c.branch_type      = BR_NONE;
        c.instruction_type = t;
        c.rs1              = r1;
        c.rs2              = r2;
        c.rd               = rd;
        return c;
    endfunction

    function automatic logic [31:0] rs1_of(logic [31:0] pc); return pc + 32'h0000_1000; endfunction
    function automatic logic [31:0] rs2_of(logic [31:0] pc); return pc + 32'h0000_2000; endfunction
    function automatic logic [31:0] imm_of(logic [31:0] pc); return pc ^ 32'hffff_0000; endfunction

    task automatic add_v(logic v, control_signals_t c, logic [31:0] pc, logic fl, logic rdy,
                         logic es, logic ev, control_signals_t ec, logic [31:0] epc, int ecnt);
        vec_t r;
        r.valid = v; r.ctrl = c; r.pc = pc; r.flush = fl; r.ready = rdy;
        r.exp_stall = es; r.exp_valid = ev; r.exp_ctrl = ec; r.exp_pc = epc; r.exp_cnt = ecnt;
        vecs.push_back(r);
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        control_signals_t lw5, add_dep, lw0, add0, lui5, addi, sw, add1, lw6, add6, bub;
        int sat;

        bub     = CTRL_BUBBLE;
        lw5     = mk(OP_LOAD,   1'b1, 5'd1, 5'd0, 5'd5);
        add_dep = mk(OP_R_TYPE, 1'b1, 5'd5, 5'd7, 5'd6);
        lw0     = mk(OP_LOAD,   1'b1, 5'd2, 5'd0, 5'd0);
        add0    = mk(OP_R_TYPE, 1'b1, 5'd0, 5'd0, 5'd7);
        lui5    = mk(OP_LUI,    1'b1, 5'd5, 5'd0, 5'd5);
        addi    = mk(OP_I_TYPE, 1'b1, 5'd3, 5'd5, 5'd8);
        sw      = mk(OP_STORE,  1'b0, 5'd2, 5'd5, 5'd0);
        add1    = mk(OP_R_TYPE, 1'b1, 5'd1, 5'd2, 5'd9);
        lw6     = mk(OP_LOAD,   1'b1, 5'd5, 5'd0, 5'd6);
        add6    = mk(OP_R_TYPE, 1'b1, 5'd6, 5'd3, 5'd10);

        // valid ctrl pc flush ready | stall valid ctrl pc cnt
        add_v(1, lw5,     32'h100, 0, 1,  0, 1, lw5,     32'h100, 0);
        add_v(1, add_dep, 32'h104, 0, 1,  1, 0, bub,     32'h100, 1);
        add_v(1, add_dep, 32'h104, 0, 1,  0, 1, add_dep, 32'h104, 1);
        add_v(1, lw0,     32'h108, 0, 1,  0, 1, lw0,     32'h108, 1);
        add_v(1, add0,    32'h10c, 0, 1,  0, 1, add0,    32'h10c, 1);
        add_v(1, lw5,     32'h110, 0, 1,  0, 1, lw5,     32'h110, 1);
        add_v(1, lui5,    32'h114, 0, 1,  0, 1, lui5,    32'h114, 1);
        add_v(1, lw5,     32'h118, 0, 1,  0, 1, lw5,     32'h118, 1);
        add_v(1, addi,    32'h11c, 0, 1,  0, 1, addi,    32'h11c, 1);
        add_v(1, lw5,     32'h120, 0, 1,  0, 1, lw5,     32'h120, 1);
        add_v(1, sw,      32'h124, 0, 1,  1, 0, bub,     32'h120, 2);
        add_v(1, sw,      32'h124, 0, 1,  0, 1, sw,      32'h124, 2);
        add_v(1, add1,    32'h128, 0, 0,  1, 1, sw,      32'h124, 2);
        add_v(1, add1,    32'h128, 0, 0,  1, 1, sw,      32'h124, 2);
        add_v(1, add1,    32'h128, 0, 0,  1, 1, sw,      32'h124, 2);
        add_v(1, add1,    32'h128, 0, 1,  0, 1, add1,    32'h128, 2);
        add_v(1, lw5,     32'h12c, 0, 1,  0, 1, lw5,     32'h12c, 2);
        add_v(1, lw6,     32'h130, 0, 1,  1, 0, bub,     32'h12c, 3);
        add_v(1, lw6,     32'h130, 0, 1,  0, 1, lw6,     32'h130, 3);
        add_v(1, add6,    32'h134, 0, 1,  1, 0, bub,     32'h130, 4);
        add_v(1, add6,    32'h134, 0, 1,  0, 1, add6,    32'h134, 4);
        add_v(1, lw5,     32'h138, 0, 1,  0, 1, lw5,     32'h138, 4);
        add_v(1, add_dep, 32'h13c, 1, 0,  0, 0, bub,     32'h138, 4);
        add_v(1, add_dep, 32'h13c, 0, 1,  0, 1, add_dep, 32'h13c, 4);
        add_v(0, lw5,     32'h140, 0, 1,  0, 0, bub,     32'h140, 4);
        add_v(1, lw5,     32'h144, 0, 1,  0, 1, lw5,     32'h144, 4);
        add_v(0, add_dep, 32'h148, 0, 1,  0, 0, bub,     32'h148, 4);
        add_v(1, lw5,     32'h14c, 0, 1,  0, 1, lw5,     32'h14c, 4);
        add_v(1, add_dep, 32'h150, 0, 1,  1, 0, bub,     32'h14c, 5);
        add_v(1, add_dep, 32'h150, 0, 1,  0, 1, add_dep, 32'h150, 5);

        rst_n = 1'b0; id_valid = 1'b0; id_ctrl = bub; id_pc = '0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; flush = 1'b0; ex_ready = 1'b1;
        #12;
        chk("reset_valid", 64'(ex_valid), 64'(1'b0));
        chk("reset_ctrl",  64'(ex_ctrl), 64'(bub));
        chk("reset_pc",    64'(ex_pc), 64'h0);
        chk("reset_rs1",   64'(ex_rs1_data), 64'h0);
        chk("reset_cnt",   64'(stall_count), 64'h0);
        chk("reset_cnt_sat", 64'(s_stall_count), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            id_valid    = vecs[i].valid;
            id_ctrl     = vecs[i].ctrl;
            id_pc       = vecs[i].pc;
            id_rs1_data = rs1_of(vecs[i].pc);
            id_rs2_data = rs2_of(vecs[i].pc);
            id_imm      = imm_of(vecs[i].pc);
            flush       = vecs[i].flush;
            ex_ready    = vecs[i].ready;
            #2;
            chk($sformatf("v%0d_id_stall", i), 64'(id_stall), 64'(vecs[i].exp_stall));
            @(posedge clk);
            #1;
            sat = (vecs[i].exp_cnt > 3) ? 3 : vecs[i].exp_cnt;
            chk($sformatf("v%0d_ex_valid", i), 64'(ex_valid), 64'(vecs[i].exp_valid));
            chk($sformatf("v%0d_ex_ctrl", i),  64'(ex_ctrl), 64'(vecs[i].exp_ctrl));
            chk($sformatf("v%0d_ex_pc", i),    64'(ex_pc), 64'(vecs[i].exp_pc));
            chk($sformatf("v%0d_ex_rs1", i),   64'(ex_rs1_data), 64'(rs1_of(vecs[i].exp_pc)));
            chk($sformatf("v%0d_ex_rs2", i),   64'(ex_rs2_data), 64'(rs2_of(vecs[i].exp_pc)));
            chk($sformatf("v%0d_ex_imm", i),   64'(ex_imm), 64'(imm_of(vecs[i].exp_pc)));
            chk($sformatf("v%0d_cnt", i),      64'(stall_count), 64'(vecs[i].exp_cnt));
            chk($sformatf("v%0d_cnt_sat", i),  64'(s_stall_count), 64'(sat));
        end

        // Asynchronous reset mid-stream with a real instruction in EX.
        chk("pre_rst_valid", 64'(ex_valid), 64'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid",   64'(ex_valid), 64'(1'b0));
        chk("midrst_ctrl",    64'(ex_ctrl), 64'(bub));
        chk("midrst_pc",      64'(ex_pc), 64'h0);
        chk("midrst_cnt",     64'(stall_count), 64'h0);
        chk("midrst_cnt_sat", 64'(s_stall_count), 64'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", 64'(ex_valid), 64'(1'b0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
